instr_fetch_unit: RTL
=====================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, byte address of the first fetch after reset.
REQ-002 Parameter FQ_DEPTH, 2, fetch-queue entries (power of two, >=2); also the cap on outstanding memory requests.
REQ-003 One clock; reset is asynchronous and active-high; ports are named clk and reset.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 imem_req  output  1  instruction-memory request valid.
REQ-007 imem_addr  output  XLEN  byte address of the request; bits [1:0] are always 00.
REQ-008 imem_gnt  input  1  request accepted this cycle when imem_req=1.
REQ-009 imem_rvalid  input  1  read data valid; responses return in request order, at least 1 cycle after grant.
REQ-010 imem_rdata  input  XLEN  instruction word.
REQ-011 stall_i  input  1  decode cannot accept (hazard stall); holds the head entry.
REQ-012 redirect_i  input  1  taken branch/jump from execute (PCSrcE).
REQ-013 redirect_pc_i  input  XLEN  target address (PCTargetE).
REQ-014 instr_valid_o  output  1  instr_o/pc_o/pc_plus4_o are valid.
REQ-015 instr_o  output  XLEN  instruction to the IF/ID register (InstrF).
REQ-016 pc_o  output  XLEN  address of instr_o (PCF).
REQ-017 pc_plus4_o  output  XLEN  pc_o + 4 (PCPlus4F).

Function
REQ-018 Fetch PC register fpc; a request is issued at fpc, and fpc += 4 (mod 2^32, wrap from FFFF_FFFC to 0) on each req&gnt.
REQ-019 imem_req = !reset & !redirect_i & (outstanding + queue_count < FQ_DEPTH); every accepted request has a reserved queue slot.
REQ-020 imem_req and imem_addr stay stable while imem_req=1 and imem_gnt=0.
REQ-021 outstanding counter: +1 on req&gnt, -1 on rvalid; both in one cycle leave it unchanged.
REQ-022 On rvalid with discard_cnt=0, {imem_rdata, pc of that request} is written to the queue tail; queue never overflows.
REQ-023 Outputs are driven from the queue head only (registered); rvalid at cycle N gives instr_valid_o at N+1 at the earliest; no bypass.
REQ-024 instr_valid_o = (queue_count != 0); head pops when instr_valid_o & !stall_i.
REQ-025 Simultaneous push and pop at full or empty are legal and keep the count consistent.
REQ-026 Redirect cycle: queue flushed; fpc <= {redirect_pc_i[XLEN-1:2], 2'b00}; discard_cnt <= outstanding minus any response returned that same cycle; imem_req = 0.
REQ-027 Responses arriving while discard_cnt>0 are dropped and decrement discard_cnt; a new fetch may issue during discard.
REQ-028 Redirect while stall_i=1 still flushes; the flush overrides the stall.
REQ-029 A redirect while discard_cnt>0 adds the current outstanding count; discard_cnt saturates at FQ_DEPTH.

Reset
REQ-030 Reset values: fpc=RESET_PC, outstanding=0, discard_cnt=0, queue empty, instr_valid_o=0, imem_req=0, imem_addr=RESET_PC, instr_o=0, pc_o=0, pc_plus4_o=4.
REQ-031 Reset asserted mid-operation abandons all in-flight requests; responses returned during reset are ignored.
REQ-032 The first request is issued in the first cycle after reset deasserts.

Structure
REQ-033 types_pkg holds word_t, XLEN and a new fetch_entry_t {instr, pc}; FQ_DEPTH default is a types_pkg constant.
REQ-034 The queue is a sub-module fetch_queue (circular buffer, count, push/pop/flush); the counters and fpc stay in instr_fetch_unit.

Verification
REQ-035 Reset release, gnt=1, 1-cycle rvalid, stall=0 -> addresses 0,4,8... on successive cycles; first instr_valid_o 2 cycles after first grant, with pc_o=0 and pc_plus4_o=4.
REQ-036 stall_i held 3 cycles with queue full -> imem_req=0, pc_o held constant, no lost or duplicated instruction after release.
REQ-037 redirect_i to 0x100 with 2 outstanding -> next 2 responses dropped, next imem_addr=0x100, first valid pc_o=0x100.
REQ-038 redirect_pc_i=0x203 -> imem_addr=0x200.
REQ-039 gnt low 4 cycles -> imem_addr held stable at the same value throughout.
REQ-040 fpc=FFFF_FFFC -> next imem_addr=0000_0000; reset asserted with 2 outstanding -> all outputs return to REQ-030 values on the same edge.

Source files
------------

// File: rtl/types_pkg.sv
// Shared types for the instruction fetch path: machine word and fetch-queue entry.
package types_pkg;
    localparam int XLEN             = 32;
    localparam int FQ_DEPTH_DEFAULT = 2;

    typedef logic [XLEN-1:0] word_t;

    typedef struct packed {
        word_t instr;
        word_t pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Circular buffer holding fetched {instr, pc} pairs between instruction memory and decode.
module fetch_queue
    import types_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH_DEFAULT,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  fetch_entry_t  push_data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output fetch_entry_t  head_o,
    output logic [CW-1:0] count_o
);
    localparam int            PW   = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;
    fetch_entry_t  mem_q [DEPTH];

    always_comb begin
        do_pop   = pop_i && !flush_i && (count_q != '0);
        // Pushing into a full queue is fine when the head leaves in the same cycle.
        do_push  = push_i && !flush_i && ((count_q != FULL) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: issues in-order word fetches, tracks in-flight requests,
// drops stale responses after a redirect and presents fetched words from a queue.
module instr_fetch_unit
    import types_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000,
    parameter int    FQ_DEPTH = FQ_DEPTH_DEFAULT
) (
    input  logic  clk,
    input  logic  reset,
    output logic  imem_req,
    output word_t imem_addr,
    input  logic  imem_gnt,
    input  logic  imem_rvalid,
    input  word_t imem_rdata,
    input  logic  stall_i,
    input  logic  redirect_i,
    input  word_t redirect_pc_i,
    output logic  instr_valid_o,
    output word_t instr_o,
    output word_t pc_o,
    output word_t pc_plus4_o
);
    localparam int CW = $clog2(FQ_DEPTH) + 1;
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t  DEPTH_C   = cnt_t'(FQ_DEPTH);
    localparam word_t RESET_FPC = RESET_PC & ~word_t'(3);

    word_t        fpc_q, fpc_d, rsp_pc_q, rsp_pc_d;
    cnt_t         outstanding_q, outstanding_d, discard_q, discard_d, q_count;
    logic [CW:0]  in_flight;
    logic         fire, keep_rsp, q_push, q_pop;
    fetch_entry_t head, push_entry;

    function automatic cnt_t sat_depth(input logic [CW:0] v);
        return (v > {1'b0, DEPTH_C}) ? DEPTH_C : v[CW-1:0];
    endfunction

    always_comb begin
        instr_valid_o = (q_count != '0);
        instr_o       = instr_valid_o ? head.instr : '0;
        pc_o          = instr_valid_o ? head.pc : '0;
        pc_plus4_o    = pc_o + 32'd4;
    end

    // Every accepted request already owns a queue slot, so the queue cannot overflow.
    always_comb begin
        in_flight  = {1'b0, outstanding_q} + {1'b0, q_count};
        imem_req   = !reset && !redirect_i && (in_flight < {1'b0, DEPTH_C});
        fire       = imem_req && imem_gnt;
        keep_rsp   = imem_rvalid && (discard_q == '0);
        q_push     = keep_rsp && !redirect_i;
        q_pop      = instr_valid_o && !stall_i;
        push_entry = '{instr: imem_rdata, pc: rsp_pc_q};
    end

    assign imem_addr = fpc_q;

    always_comb begin
        fpc_d         = fpc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        case ({fire, imem_rvalid})
            2'b10:   outstanding_d = outstanding_q + cnt_t'(1);
            2'b01:   outstanding_d = outstanding_q - cnt_t'(1);
            default: outstanding_d = outstanding_q;
        endcase
        if (redirect_i) begin
            fpc_d    = redirect_pc_i & ~word_t'(3);
            rsp_pc_d = redirect_pc_i & ~word_t'(3);
            // Outstanding already counts responses still owed to an earlier redirect,
            // so everything in flight (less what returns now) becomes stale.
            discard_d = sat_depth({1'b0, outstanding_q} - {{CW{1'b0}}, imem_rvalid});
        end else begin
            if (fire)                             fpc_d     = fpc_q + 32'd4;
            if (imem_rvalid && discard_q != '0)   discard_d = discard_q - cnt_t'(1);
            if (keep_rsp)                         rsp_pc_d  = rsp_pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fpc_q         <= RESET_FPC;
            rsp_pc_q      <= RESET_FPC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fpc_q         <= fpc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH),
        .CW    (CW)
    ) u_queue (
        .clk         (clk),
        .reset       (reset),
        .push_i      (q_push),
        .push_data_i (push_entry),
        .pop_i       (q_pop),
        .flush_i     (redirect_i),
        .head_o      (head),
        .count_o     (q_count)
    );
endmodule
